// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding used by
// CU decode and the MDU, plus the busy-counter width.
package mdu_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational datapath for MULT/MULTU/DIV/DIVU producing {hi,lo}.
// The ctrl block only models latency; the value is ready in the accept cycle.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        div_ovf;
    logic [31:0] rt_safe;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divisor forced to 1 for /0 and INT_MIN/-1: the latter then yields
    // quotient 0x80000000, remainder 0 without needing a separate mux.
    assign div_ovf     = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign div_by_zero = is_div(op) && (rt_val == 32'd0);
    assign rt_safe     = ((rt_val == 32'd0) || div_ovf) ? 32'd1 : rt_val;

    assign quot_s = $signed(rs_val) / $signed(rt_safe);
    assign rem_s  = $signed(rs_val) % $signed(rt_safe);
    assign quot_u = rs_val / rt_safe;
    assign rem_u  = rs_val % rt_safe;

    always_comb begin
        result = '0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quot_s};
            MD_DIVU:  result = {rem_u, quot_u};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: HI/LO ownership, fixed-latency busy counter, pending result
// and the D-stage stall request for the hazard unit.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [63:0]      pending_reg, pending_next;
    logic             pending_wr_reg, pending_wr_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [63:0]      arith_result;
    logic             div_by_zero;
    logic             accept;

    mdu_arith u_arith (
        .op          (md_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .result      (arith_result),
        .div_by_zero (div_by_zero)
    );

    assign busy   = (cnt_reg != '0);
    assign accept = start && !busy;

    always_comb begin
        cnt_next        = cnt_reg;
        pending_next    = pending_reg;
        pending_wr_next = pending_wr_reg;
        hi_next         = hi_reg;
        lo_next         = lo_reg;
        if (busy) begin
            cnt_next = cnt_reg - ONE;
            // Commit on the edge where busy falls; /0 leaves HI/LO alone.
            if (cnt_reg == ONE && pending_wr_reg) begin
                {hi_next, lo_next} = pending_reg;
            end
        end
        if (accept) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    cnt_next        = MULT_N;
                    pending_next    = arith_result;
                    pending_wr_next = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    cnt_next        = DIV_N;
                    pending_next    = arith_result;
                    pending_wr_next = !div_by_zero;
                end
                MD_MTHI: hi_next = rs_val;
                MD_MTLO: lo_next = rs_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            pending_reg    <= '0;
            pending_wr_reg <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
        end else begin
            cnt_reg        <= cnt_next;
            pending_reg    <= pending_next;
            pending_wr_reg <= pending_wr_next;
            hi_reg         <= hi_next;
            lo_reg         <= lo_next;
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign stall = d_is_md && (busy || (start && (is_mul(md_op) || is_div(md_op))));

    always_comb begin
        md_out = '0;
        if (start && md_op == MD_MFHI) md_out = hi_reg;
        if (start && md_op == MD_MFLO) md_out = lo_reg;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected {hi,lo} pushed on issue, popped when busy drops.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          passed = 0;
    int          illegal_starts = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_hl;
    int          n;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .md_out  (md_out),
        .hi      (hi),
        .lo      (lo)
    );

    // Protocol monitor: the hazard unit must never issue while busy.
    always @(posedge clk) begin
        if (!reset && start && busy) begin
            illegal_starts <= illegal_starts + 1;
            $display("note: start asserted while busy at %0t (ignored by DUT)", $time);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
        $display("check %-22s got %h expected %h", tag, obs, expv);
    endtask

    task automatic idle();
        start = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0; d_is_md = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        e = sb_q.pop_front();
        check({tag, ".hi"}, hi, e[63:32]);
        check({tag, ".lo"}, lo, e[31:0]);
    endtask

    // Issue a MULT/DIV immediately (caller is in a cycle with busy=0).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_v, input int exp_n);
        int c;
        sb_q.push_back(exp_v);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        idle();
        count_busy(c);
        check({tag, ".busy_cycles"}, 32'(c), 32'(exp_n));
        pop_check(tag);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        d_is_md = 1'b1;
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        check("reset.md_out", md_out, 32'd0);
        reset = 1'b0;

        // MTHI then MFHI right behind it: no stall, forwarded value read back
        @(negedge clk);
        start = 1'b1; md_op = MD_MTHI; rs_val = 32'h1234_5678; d_is_md = 1'b1;
        #1 check("mthi.stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b1; md_op = MD_MFHI; rs_val = '0; d_is_md = 1'b0;
        #1 check("mfhi.md_out", md_out, 32'h1234_5678);
        @(negedge clk);
        start = 1'b1; md_op = MD_MTLO; rs_val = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b1; md_op = MD_MFLO; rs_val = '0;
        #1 check("mflo.md_out", md_out, 32'hCAFE_F00D);

        // Reset two edges after a MULT is accepted: pending result must be lost
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge clk);
        idle();
        check("rstmid.busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.hi", hi, 32'd0);
        check("rstmid.lo", lo, 32'd0);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        check("rstmid.hi_later", hi, 32'd0);
        check("rstmid.lo_later", lo, 32'd0);
        check("rstmid.busy_later", 32'(busy), 32'd0);

        // Back-to-back arithmetic, each issued in the first cycle busy is low
        run_op("mult",    MD_MULT,  32'hFFFF_FFFE, 32'd3,        {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5);
        run_op("multu",   MD_MULTU, 32'hFFFF_FFFE, 32'd3,        {32'h0000_0002, 32'hFFFF_FFFA}, 5);
        run_op("div_m7_2", MD_DIV,  32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
        run_op("div_7_m2", MD_DIV,  32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 10);
        run_op("div_ovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 10);
        run_op("divu_by0", MD_DIVU, 32'd7,         32'd0,        {32'h0000_0000, 32'h8000_0000}, 10);
        run_op("divu",    MD_DIVU,  32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E}, 10);

        // MULT in E with MFLO in D: stall for start cycle + 5 busy cycles
        sb_q.push_back({32'd0, 32'd63});
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd7; rt_val = 32'd9; d_is_md = 1'b1;
        #1 n = stall ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        check("stall.cycles", 32'(n), 32'd6);
        exp_hl = sb_q.pop_front();
        start = 1'b1; md_op = MD_MFLO; rs_val = '0; rt_val = '0; d_is_md = 1'b0;
        #1;
        check("stall.mflo_md_out", md_out, exp_hl[31:0]);
        check("stall.mflo_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        idle();
        @(negedge clk);

        // Forced start while busy: ignored, original MULT completes on time
        sb_q.push_back({32'd0, 32'd6});
        start = 1'b1; md_op = MD_MULT; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk); #1;
        md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd10;
        @(negedge clk);
        n = busy ? 1 : 0;
        @(posedge clk); #1;
        idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("forced.busy_cycles", 32'(n), 32'd5);
        pop_check("forced");
        check("forced.monitor", 32'(illegal_starts), 32'd1);

        // NONE and an undefined code with start=1: no effect anywhere
        start = 1'b1; md_op = MD_NONE; rs_val = 32'hDEAD_BEEF; rt_val = 32'd1; d_is_md = 1'b1;
        #1 check("none.md_out", md_out, 32'd0);
        check("none.stall", 32'(stall), 32'd0);
        @(negedge clk);
        md_op = 4'hF;
        #1 check("undef.md_out", md_out, 32'd0);
        @(negedge clk);
        idle();
        check("undef.busy", 32'(busy), 32'd0);
        check("undef.hi", hi, 32'd0);
        check("undef.lo", lo, 32'd6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
